// File: rtl/weighted_rr_arbiter.sv
// Weighted round-robin arbiter: the owner holds a registered one-hot grant for
// up to its programmed weight in cycles, or until it drops its request.
module weighted_rr_arbiter #(
  parameter int NUM_REQUESTORS = 4,
  parameter int WEIGHT_WIDTH   = 4,
  parameter int ID_WIDTH       = $clog2(NUM_REQUESTORS)
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic [NUM_REQUESTORS-1:0]              req,
  input  logic [NUM_REQUESTORS*WEIGHT_WIDTH-1:0] weights,
  output logic [NUM_REQUESTORS-1:0]              grant,
  output logic                                   grant_valid,
  output logic [ID_WIDTH-1:0]                    grant_id,
  output logic [WEIGHT_WIDTH-1:0]                tenure_left
);

  typedef enum logic {IDLE, OWN} state_t;

  state_t                    state, state_n;
  logic [ID_WIDTH-1:0]       owner, owner_n;
  logic [ID_WIDTH-1:0]       ptr, ptr_n;
  logic [ID_WIDTH-1:0]       owner_inc, scan_base, sel;
  logic [WEIGHT_WIDTH-1:0]   count, count_n;
  logic [NUM_REQUESTORS-1:0] grant_n;
  logic                      sel_valid, end_tenure, found;
  int unsigned               idx;
  logic [WEIGHT_WIDTH-1:0]   w_eff [NUM_REQUESTORS];

  always_comb begin
    for (int unsigned i = 0; i < NUM_REQUESTORS; i++) begin
      w_eff[i] = weights[i*WEIGHT_WIDTH +: WEIGHT_WIDTH];
      if (w_eff[i] == '0) w_eff[i] = WEIGHT_WIDTH'(1);
    end
  end

  always_comb begin
    owner_inc = (owner == ID_WIDTH'(NUM_REQUESTORS - 1)) ? '0 : owner + ID_WIDTH'(1);
  end

  // At tenure end the scan already starts from the ptr value being written.
  always_comb begin
    scan_base = (state == OWN) ? owner_inc : ptr;
    sel       = '0;
    found     = 1'b0;
    idx       = 0;
    for (int unsigned i = 0; i < NUM_REQUESTORS; i++) begin
      idx = (32'(scan_base) + i) % NUM_REQUESTORS;
      if (!found && req[idx[ID_WIDTH-1:0]]) begin
        sel   = idx[ID_WIDTH-1:0];
        found = 1'b1;
      end
    end
    sel_valid = |req;
  end

  always_comb begin
    state_n    = state;
    owner_n    = owner;
    count_n    = count;
    ptr_n      = ptr;
    grant_n    = grant;
    end_tenure = !req[owner] || (count == WEIGHT_WIDTH'(1));
    case (state)
      IDLE: begin
        grant_n = '0;
        if (sel_valid) begin
          state_n      = OWN;
          owner_n      = sel;
          count_n      = w_eff[sel];
          grant_n[sel] = 1'b1;
        end
      end
      OWN: begin
        if (!end_tenure) begin
          count_n = count - WEIGHT_WIDTH'(1);
        end else begin
          ptr_n   = owner_inc;
          grant_n = '0;
          if (sel_valid) begin
            owner_n      = sel;
            count_n      = w_eff[sel];
            grant_n[sel] = 1'b1;
          end else begin
            state_n = IDLE;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      owner <= '0;
      count <= '0;
      ptr   <= '0;
      grant <= '0;
    end else begin
      state <= state_n;
      owner <= owner_n;
      count <= count_n;
      ptr   <= ptr_n;
      grant <= grant_n;
    end
  end

  always_comb begin
    grant_valid = |grant;
    grant_id    = (state == OWN) ? owner : '0;
    tenure_left = (state == OWN) ? count : '0;
  end

endmodule

// File: doc/weighted_rr_arbiter.md
# weighted_rr_arbiter

Weighted round-robin arbiter with burst tenure. It shares one downstream resource among `NUM_REQUESTORS` requesters. The grant is registered and one-hot. The owner keeps the grant for up to its programmed weight in cycles, or until it drops its request; ownership then rotates round-robin. It sits alongside the matrix-priority arbiter in the arbiters library and is used where bandwidth shares, rather than pairwise priority, must be enforced.

## Interface
Parameters:
- `NUM_REQUESTORS`, 4: number of requesters; must be ≥2.
- `WEIGHT_WIDTH`, 4: width of each per-requester weight and of the tenure counter.
- `ID_WIDTH`, `$clog2(NUM_REQUESTORS)`: width of `grant_id`.

Ports:
- `clk` input 1: single clock, rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `req` input `NUM_REQUESTORS`: request per requester. Held high for as long as the requester wants the resource.
- `weights` input `NUM_REQUESTORS*WEIGHT_WIDTH`: weight of requester i at `[i*WEIGHT_WIDTH +: WEIGHT_WIDTH]`, giving the maximum tenure in cycles.
- `grant` output `NUM_REQUESTORS`: registered one-hot grant.
- `grant_valid` output 1: `|grant`.
- `grant_id` output `ID_WIDTH`: index of the granted requester; 0 when no grant.
- `tenure_left` output `WEIGHT_WIDTH`: cycles remaining in the current tenure, including the current cycle; 0 when idle.

## Operation
- **State**:
  - `state` is one of IDLE or OWN.
  - `owner` (`ID_WIDTH`).
  - `count` (`WEIGHT_WIDTH`).
  - `ptr` (`ID_WIDTH`): round-robin start index.
- **Effective weight**: `w_eff(i) = (weight_i == 0) ? 1 : weight_i`. The weight is sampled only at tenure start. Changes to `weights` during a tenure are ignored until that requester's next tenure.
- **Selection** (combinational): `sel` is the first index i with `req[i]=1`, scanning `ptr, ptr+1, ..., ptr+N-1` mod N. `sel_valid = |req`.
- **IDLE**:
  - On an edge with `sel_valid=1`: go to OWN, `owner<=sel`, `count<=w_eff(sel)`, grant one-hot at `sel`.
  - Otherwise stay in IDLE with grant 0.
- **OWN**, at each edge:
  - `end_tenure = !req[owner] || count==1`.
  - **Not end**: `count<=count-1`; grant unchanged.
  - **End**: `ptr<=(owner+1) mod N`. Selection then restarts from the new ptr (`owner+1`), using the current `req`.
    - If `sel_valid`: stay in OWN, `owner<=sel`, `count<=w_eff(sel)`, grant moves to `sel` with no idle gap.
    - Otherwise: go to IDLE with grant 0.
- **Sole requester**: the previous owner may re-win when it is the only requester still asserting `req`. Its grant then stays continuously high and `count` reloads.
- **`ptr` updates** only at tenure end; it does not change in IDLE.
- **`tenure_left`**: equals `count` in OWN and 0 in IDLE.
- **Arithmetic**: `count` never wraps. It is never decremented below 1, because the value 1 always ends the tenure.

## Timing
- **Reset** (asynchronous, immediate): `state=IDLE`, `grant=0`, `grant_valid=0`, `grant_id=0`, `tenure_left=0`, `ptr=0`, `owner=0`, `count=0`.
  - A reset asserted mid-tenure drops the grant immediately, without waiting for a clock edge.
  - After reset deasserts, arbitration starts from index 0.
- **Grant latency**: `req` sampled high at edge k in IDLE gives `grant` high in the cycle after edge k. That is 1 cycle from the cycle of `req` assertion.
- **Tenure length**: a continuously requesting owner holds the grant for exactly `w_eff` cycles.
- **Early release**: the grant deasserts at the first edge where `req[owner]` is sampled 0. The owner therefore sees one cycle with `grant=1` while its `req=0`, and must not transfer in that cycle.
- **Hand-over**: the old grant falls and the new grant rises on the same edge. No cycle has two bits of `grant` set.
- **Simultaneous events**: `req[owner]` dropping on the same edge that `count==1` is one tenure end, with a single `ptr` update.
- **Request rising during another's tenure**: no effect until tenure end.
- **Outputs**: all outputs are registered, or derived only from registered state. There are no combinational paths from `req` or `weights` to any output.

## Test plan
- **Reset and single requester**: reset, then `req=4'b0001`, `weights` all 3 → grant is 0 during reset. `grant=0001` from the cycle after `req`, and it stays high continuously. `tenure_left` cycles 3,2,1,3,2,1.
- **Weighted sharing**: `req=0011` held, w0=2, w1=1 → `grant_id` sequence 0,0,1,0,0,1 repeating. Never two grant bits set.
- **Early release and zero weight**: owner 2 with w2=5 drops `req` after 2 granted cycles → grant falls at the next edge, `ptr=3`. Then w3=0 with `req[3]` high → a 1-cycle tenure.
- **Round-robin fairness**: `req=1111`, all weights 1 → `grant_id` 0,1,2,3,0 with no gaps. Then drop `req[1]` → sequence skips 1.
- **Weight change mid-tenure**: owner 0 has w0=4; at tenure cycle 2, write w0=1 → the tenure still lasts 4 cycles, and the next tenure of requester 0 lasts 1 cycle.
- **Reset mid-tenure**: assert `rst` asynchronously at tenure cycle 2 → `grant`, `grant_valid`, `tenure_left` are 0 before the next edge. After release with `req=1000`, the grant goes to 3, with the scan starting from `ptr=0`.
